// File: rtl/seven_segment_scan_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the capture FSM state encoding, the abcdefg segment patterns for
// the hex digits 0-F (bit 6 = segment a ... bit 0 = segment g, 1 = lit),
// the digit slot indices and a small one-hot helper.
// The optional hex letter decode is switched by SEVEN_SEGMENT_HEX_DECODE_EN.
// This macro is consumed by segment_pattern_decoder.
package seven_segment_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_PAT_0     = 7'b1111110;
    localparam logic [6:0] SEG_PAT_1     = 7'b0110000;
    localparam logic [6:0] SEG_PAT_2     = 7'b1101101;
    localparam logic [6:0] SEG_PAT_3     = 7'b1111001;
    localparam logic [6:0] SEG_PAT_4     = 7'b0110011;
    localparam logic [6:0] SEG_PAT_5     = 7'b1011011;
    localparam logic [6:0] SEG_PAT_6     = 7'b1011111;
    localparam logic [6:0] SEG_PAT_7     = 7'b1110000;
    localparam logic [6:0] SEG_PAT_8     = 7'b1111111;
    localparam logic [6:0] SEG_PAT_9     = 7'b1111011;
    localparam logic [6:0] SEG_PAT_A     = 7'b1110111;
    localparam logic [6:0] SEG_PAT_B     = 7'b0011111;
    localparam logic [6:0] SEG_PAT_C     = 7'b1001110;
    localparam logic [6:0] SEG_PAT_D     = 7'b0111101;
    localparam logic [6:0] SEG_PAT_E     = 7'b1001111;
    localparam logic [6:0] SEG_PAT_F     = 7'b1000111;
    localparam logic [6:0] SEG_PAT_BLANK = 7'b0000000;

    localparam int NUM_DIGITS = 3;
    localparam int DIGIT1_IDX = 0;
    localparam int DIGIT2_IDX = 1;
    localparam int DIGIT3_IDX = 2;

    // A slot is only meaningful when exactly one digit is selected; zero
    // selects are blanking gaps and several selects are ghosting.
    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/seven_segment_scan_decoder_segment_pattern_decoder.sv
// segment_pattern_decoder
// Purely combinational translation of a normalized abcdefg pattern
// (1 = lit) into a digit value.
// Ports:
//   i_pattern - 7-bit pattern, bit 6 = a ... bit 0 = g
//   o_valid   - pattern is a recognised digit or all segments off
//   o_blank   - pattern is all segments off
//   o_value   - decoded value (0 when blank or unrecognised)
// Macro SEVEN_SEGMENT_HEX_DECODE_EN adds the letters A, b, C, d, E and F.
module segment_pattern_decoder
    import seven_segment_scan_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_valid,
    output logic       o_blank,
    output logic [3:0] o_value
);

    // Table lookup; anything not listed falls through to "not valid" so the
    // capture logic can flag it without touching the digit register.
    always_comb begin
        o_valid = 1'b1;
        o_blank = 1'b0;
        o_value = 4'h0;
        case (i_pattern)
            SEG_PAT_0:     o_value = 4'h0;
            SEG_PAT_1:     o_value = 4'h1;
            SEG_PAT_2:     o_value = 4'h2;
            SEG_PAT_3:     o_value = 4'h3;
            SEG_PAT_4:     o_value = 4'h4;
            SEG_PAT_5:     o_value = 4'h5;
            SEG_PAT_6:     o_value = 4'h6;
            SEG_PAT_7:     o_value = 4'h7;
            SEG_PAT_8:     o_value = 4'h8;
            SEG_PAT_9:     o_value = 4'h9;
            SEG_PAT_BLANK: o_blank = 1'b1;
`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
            SEG_PAT_A:     o_value = 4'hA;
            SEG_PAT_B:     o_value = 4'hB;
            SEG_PAT_C:     o_value = 4'hC;
            SEG_PAT_D:     o_value = 4'hD;
            SEG_PAT_E:     o_value = 4'hE;
            SEG_PAT_F:     o_value = 4'hF;
`endif
            default:       o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
// Monitors a multiplexed seven-segment display bus and recovers the digit
// shown in each of the three slots.  Each slot must hold the same sampled
// segment/enable value for STABLE_CYCLES clocks before it is decoded once.
// Ports:
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_sevenSegment        - segment bus, [7:1] = a..g, [0] = dp
//   i_sevenSegmentEnable  - digit selects, [0] = digit1 .. [2] = digit3
//   o_digit1..o_digit3    - last decoded value per digit
//   o_digitValid          - digit decoded since reset / bus timeout
//   o_blank               - last capture of that digit was all segments off
//   o_frameDone           - one-cycle pulse after all three digits captured
//   o_error               - one-cycle pulse when a pattern does not decode
// Macro SEVEN_SEGMENT_HEX_DECODE_EN (in the decoder) enables A-F decode.
module seven_segment_scan_decoder
    import seven_segment_scan_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_sevenSegment,
    input  logic [2:0] i_sevenSegmentEnable,
    output logic [3:0] o_digit1,
    output logic [3:0] o_digit2,
    output logic [3:0] o_digit3,
    output logic [2:0] o_digitValid,
    output logic [2:0] o_blank,
    output logic       o_frameDone,
    output logic       o_error
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STB_W-1:0] STB_TARGET = STB_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);

    logic [10:0] sync1_q, sync1_d;
    logic [10:0] sync2_q, sync2_d;
    logic [7:0]  seg_norm;
    logic [2:0]  en_norm;
    logic [10:0] sample_now;
    logic        en_one_hot;

    scan_state_e      state_q, state_d;
    logic [10:0]      sample_q, sample_d;
    logic [STB_W-1:0] stable_cnt_q, stable_cnt_d, stable_cnt_inc;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      valid_q, valid_d;
    logic [NUM_DIGITS-1:0]      blank_q, blank_d;
    logic [NUM_DIGITS-1:0]      mask_q, mask_d;
    logic                       frame_done_q, frame_done_d;

    logic       capture_en;
    logic       error_now;
    logic       dec_valid;
    logic       dec_blank;
    logic [3:0] dec_value;

    // Synchronizer chain, then fold the bus polarity away so everything
    // downstream sees 1 = lit / selected.  The sample word is laid out as
    // {a..g, dp, enables}; dp takes part in the stability check only.
    assign sync1_d        = {i_sevenSegment, i_sevenSegmentEnable};
    assign sync2_d        = sync1_q;
    assign seg_norm       = sync2_q[10:3] ^ {8{SEG_ACTIVE_LOW}};
    assign en_norm        = sync2_q[2:0] ^ {3{EN_ACTIVE_LOW}};
    assign sample_now     = {seg_norm, en_norm};
    assign en_one_hot     = is_one_hot3(en_norm);
    assign stable_cnt_inc = stable_cnt_q + STB_W'(1);

    // The latched sample is what gets decoded, so the value written is
    // exactly the one that was seen stable for the whole settle window.
    segment_pattern_decoder u_decoder (
        .i_pattern (sample_q[10:4]),
        .o_valid   (dec_valid),
        .o_blank   (dec_blank),
        .o_value   (dec_value)
    );

    // All state lives here; reset drops everything back to an empty
    // monitor immediately, so a settle in progress is simply abandoned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= ST_IDLE;
            sample_q     <= '0;
            stable_cnt_q <= '0;
            to_cnt_q     <= '0;
            digits_q     <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            sample_q     <= sample_d;
            stable_cnt_q <= stable_cnt_d;
            to_cnt_q     <= to_cnt_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Slot tracking FSM.  IDLE waits for a single selected digit, SETTLE
    // counts identical samples (the first sample counts as one), CAPTURE
    // decodes for one cycle, and HOLD parks until the select code moves so
    // a long slot is only captured once.
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        stable_cnt_d = stable_cnt_q;
        capture_en   = 1'b0;
        error_now    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_one_hot) begin
                    sample_d     = sample_now;
                    stable_cnt_d = STB_W'(1);
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sample_now == sample_q) begin
                    stable_cnt_d = stable_cnt_inc;
                    if (stable_cnt_inc == STB_TARGET) begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    sample_d     = sample_now;
                    stable_cnt_d = STB_W'(1);
                    if (!en_one_hot) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CAPTURE: begin
                capture_en = dec_valid;
                error_now  = !dec_valid;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (en_norm != sample_q[2:0]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Digit registers, frame mask and bus-idle timeout.  The frame pulse
    // is raised the cycle after the mask fills; clearing the mask first and
    // then OR-ing in a capture lets a capture in that cycle start the next
    // frame.  The timeout clear comes last so it wins over everything, but
    // the digit values themselves are kept for readback.
    always_comb begin
        digits_d     = digits_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        mask_d       = mask_q;
        frame_done_d = 1'b0;
        to_cnt_d     = to_cnt_q;

        if (mask_q == 3'b111) begin
            frame_done_d = 1'b1;
            mask_d       = '0;
        end

        if (capture_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sample_q[i]) begin
                    valid_d[i] = 1'b1;
                    blank_d[i] = dec_blank;
                    mask_d[i]  = 1'b1;
                    if (!dec_blank) begin
                        digits_d[i] = dec_value;
                    end
                end
            end
        end

        if (en_norm == 3'b000) begin
            if (to_cnt_q != TO_LIMIT) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else if (en_one_hot) begin
            to_cnt_d = '0;
        end

        if (to_cnt_d == TO_LIMIT) begin
            valid_d = '0;
            blank_d = '0;
            mask_d  = '0;
        end
    end

    assign o_digit1     = digits_q[DIGIT1_IDX];
    assign o_digit2     = digits_q[DIGIT2_IDX];
    assign o_digit3     = digits_q[DIGIT3_IDX];
    assign o_digitValid = valid_q;
    assign o_blank      = blank_q;
    assign o_frameDone  = frame_done_q;
    assign o_error      = error_now;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed latency / reset / frame /
// timeout sequences, a vector table, and randomized slots checked against
// a slot-level reference model.  Drives an active-low bus.
module tb_seven_segment_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_bus;
    logic [2:0] en_bus;
    logic [3:0] o_digit1, o_digit2, o_digit3;
    logic [2:0] o_digitValid, o_blank;
    logic       o_frameDone, o_error;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int fd_seen = 0;

`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
    localparam int HEX_LIMIT = 16;
`else
    localparam int HEX_LIMIT = 10;
`endif

    logic [6:0] ref_pat [16];

    typedef struct {
        logic [6:0] pat;
        int         idx;
        logic [3:0] exp_digit;
        logic       exp_valid;
        logic       exp_blank;
        int         exp_err;
    } vec_t;

    vec_t vecs [8];

    logic [3:0] m_digit [3];
    logic [2:0] m_valid, m_blank, m_mask;
    int         m_frames, m_errors;

    seven_segment_scan_decoder dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_sevenSegment       (seg_bus),
        .i_sevenSegmentEnable (en_bus),
        .o_digit1             (o_digit1),
        .o_digit2             (o_digit2),
        .o_digit3             (o_digit3),
        .o_digitValid         (o_digitValid),
        .o_blank              (o_blank),
        .o_frameDone          (o_frameDone),
        .o_error              (o_error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (o_error)     err_seen <= err_seen + 1;
        if (o_frameDone) fd_seen  <= fd_seen + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Present one slot on the bus (normalized pattern/select, driven active-low).
    task automatic applyStimulus(input logic [6:0] pat, input logic dp, input logic [2:0] sel);
        @(negedge clk);
        seg_bus = ~{pat, dp};
        en_bus  = ~sel;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        seg_bus = 8'hFF;
        en_bus  = 3'b111;
        cyc(3);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] dutDigit(input int i);
        case (i)
            0:       return o_digit1;
            1:       return o_digit2;
            default: return o_digit3;
        endcase
    endfunction

    function automatic void refDecode(input logic [6:0] p, output logic ok, output logic blank, output logic [3:0] val);
        ok = 1'b0; blank = 1'b0; val = 4'h0;
        if (p == 7'b0) begin
            ok = 1'b1; blank = 1'b1;
        end else begin
            for (int k = 0; k < HEX_LIMIT; k++) begin
                if (ref_pat[k] == p) begin
                    ok = 1'b1; val = 4'(k);
                end
            end
        end
    endfunction

    // Reference: a slot held long enough on one digit is decoded once.
    function automatic void modelCapture(input int idx, input logic [6:0] pat);
        logic ok, blank;
        logic [3:0] val;
        refDecode(pat, ok, blank, val);
        if (ok) begin
            m_valid[idx] = 1'b1;
            m_blank[idx] = blank;
            if (!blank) m_digit[idx] = val;
            m_mask[idx] = 1'b1;
            if (m_mask == 3'b111) begin
                m_frames++;
                m_mask = 3'b000;
            end
        end else begin
            m_errors++;
        end
    endfunction

    // Stable slot on digit idx from reset-clean state: update exactly on the
    // 19th clock edge after the bus changes (2 sync + 16 settle + 1 capture).
    task automatic measureLatency(input string name, input int idx, input logic [3:0] val);
        logic [2:0] sel;
        sel = 3'b001 << idx;
        applyStimulus(ref_pat[val], 1'b0, sel);
        cyc(18);
        checkOutput({name, "_before"}, 32'(o_digitValid[idx]), 32'd0);
        cyc(1);
        checkOutput({name, "_valid"}, 32'(o_digitValid[idx]), 32'd1);
        checkOutput({name, "_digit"}, 32'(dutDigit(idx)), 32'(val));
    endtask

    initial begin
        int e0, f0, dur, r, idx;
        logic [6:0] pat;
        logic [2:0] sel;
        logic [2:0] ghosts [4];

        ref_pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        ghosts = '{3'b011, 3'b101, 3'b110, 3'b111};

        // Reset state
        rst = 1'b1; seg_bus = 8'hFF; en_bus = 3'b111;
        cyc(3);
        checkOutput("rst_digit1", 32'(o_digit1), 32'd0);
        checkOutput("rst_digit2", 32'(o_digit2), 32'd0);
        checkOutput("rst_digit3", 32'(o_digit3), 32'd0);
        checkOutput("rst_valid", 32'(o_digitValid), 32'd0);
        checkOutput("rst_blank", 32'(o_blank), 32'd0);
        checkOutput("rst_frame", 32'(o_frameDone), 32'd0);
        checkOutput("rst_error", 32'(o_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Digit 0 on digit1 (raw seg 8'b0000_0011, en 3'b110)
        measureLatency("lat0", 0, 4'd0);
        checkOutput("lat0_rawbus", 32'(seg_bus), 32'h03);

        // Ghosting: two selects for a while, nothing captured, no error
        e0 = err_seen;
        applyStimulus(ref_pat[5], 1'b0, 3'b011);
        cyc(300);
        checkOutput("ghost_err", 32'(err_seen - e0), 32'd0);
        checkOutput("ghost_valid", 32'(o_digitValid), 32'b001);
        checkOutput("ghost_d1", 32'(o_digit1), 32'd0);
        checkOutput("ghost_d2", 32'(o_digit2), 32'd0);

        // Reset 8 cycles into the settle window, then a full settle again
        applyStimulus(ref_pat[7], 1'b0, 3'b001);
        cyc(10);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(o_digitValid), 32'd0);
        checkOutput("midrst_d1", 32'(o_digit1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(18);
        checkOutput("midrst_before", 32'(o_digitValid[0]), 32'd0);
        cyc(1);
        checkOutput("midrst_valid2", 32'(o_digitValid[0]), 32'd1);
        checkOutput("midrst_digit", 32'(o_digit1), 32'd7);

        // Scan 1,2,3 with gaps; frameDone one cycle after the third capture
        doReset();
        f0 = fd_seen;
        applyStimulus(ref_pat[1], 1'b0, 3'b001); cyc(25);
        applyStimulus(7'b0, 1'b0, 3'b000);       cyc(4);
        applyStimulus(ref_pat[2], 1'b1, 3'b010); cyc(25);
        applyStimulus(7'b0, 1'b0, 3'b000);       cyc(4);
        applyStimulus(ref_pat[3], 1'b0, 3'b100);
        cyc(18);
        checkOutput("scan_valid_pre", 32'(o_digitValid), 32'b011);
        cyc(1);
        checkOutput("scan_valid", 32'(o_digitValid), 32'b111);
        checkOutput("scan_frame_early", 32'(o_frameDone), 32'd0);
        checkOutput("scan_digits", {20'd0, o_digit3, o_digit2, o_digit1}, 32'h321);
        cyc(1);
        checkOutput("scan_frame_pulse", 32'(o_frameDone), 32'd1);
        cyc(1);
        checkOutput("scan_frame_end", 32'(o_frameDone), 32'd0);
        cyc(10);
        checkOutput("scan_frame_count", 32'(fd_seen - f0), 32'd1);

        // Bus idle timeout: valid clears on the 50000th idle sample
        applyStimulus(7'b0, 1'b0, 3'b000);
        cyc(50001);
        checkOutput("to_before", 32'(o_digitValid), 32'b111);
        cyc(1);
        checkOutput("to_valid", 32'(o_digitValid), 32'd0);
        checkOutput("to_blank", 32'(o_blank), 32'd0);
        checkOutput("to_digits", {20'd0, o_digit3, o_digit2, o_digit1}, 32'h321);

        // Vector table, starting from digits 1/2/3 with no valid flags
        vecs[0] = '{ref_pat[4], 0, 4'd4, 1'b1, 1'b0, 0};
        vecs[1] = '{7'b0000000, 1, 4'd2, 1'b1, 1'b1, 0};
        vecs[2] = '{ref_pat[9], 2, 4'd9, 1'b1, 1'b0, 0};
`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
        vecs[3] = '{7'b1110111, 1, 4'hA, 1'b1, 1'b0, 0};
`else
        vecs[3] = '{7'b1110111, 1, 4'd2, 1'b1, 1'b1, 1};
`endif
        vecs[4] = '{7'b1010101, 0, 4'd4, 1'b1, 1'b0, 1};
        vecs[5] = '{ref_pat[8], 2, 4'd8, 1'b1, 1'b0, 0};
        vecs[6] = '{ref_pat[6], 1, 4'd6, 1'b1, 1'b0, 0};
        vecs[7] = '{ref_pat[0], 0, 4'd0, 1'b1, 1'b0, 0};
        for (int v = 0; v < 8; v++) begin
            e0  = err_seen;
            sel = 3'b001 << vecs[v].idx;
            applyStimulus(vecs[v].pat, logic'($urandom_range(0, 1)), sel);
            cyc(30);
            applyStimulus(7'b0, 1'b0, 3'b000);
            cyc(4);
            checkOutput($sformatf("vec%0d_digit", v), 32'(dutDigit(vecs[v].idx)), 32'(vecs[v].exp_digit));
            checkOutput($sformatf("vec%0d_valid", v), 32'(o_digitValid[vecs[v].idx]), 32'(vecs[v].exp_valid));
            checkOutput($sformatf("vec%0d_blank", v), 32'(o_blank[vecs[v].idx]), 32'(vecs[v].exp_blank));
            checkOutput($sformatf("vec%0d_err", v), 32'(err_seen - e0), 32'(vecs[v].exp_err));
        end

        // Randomized slots against the slot-level model
        doReset();
        for (int i = 0; i < 3; i++) m_digit[i] = 4'd0;
        m_valid = 3'b0; m_blank = 3'b0; m_mask = 3'b0;
        m_frames = 0; m_errors = 0;
        e0 = err_seen; f0 = fd_seen;
        for (int s = 0; s < 60; s++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       pat = ref_pat[$urandom_range(0, 9)];
            else if (r == 6) pat = 7'b0;
            else if (r == 7) pat = ref_pat[$urandom_range(10, 15)];
            else             pat = 7'($urandom);
            idx = int'($urandom_range(0, 2));
            sel = 3'b001 << idx;
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                dur = int'($urandom_range(22, 40));
                modelCapture(idx, pat);
            end else if (r < 85) begin
                dur = int'($urandom_range(3, 12));
            end else begin
                dur = int'($urandom_range(5, 40));
                sel = ghosts[$urandom_range(0, 3)];
            end
            applyStimulus(pat, logic'($urandom_range(0, 1)), sel);
            cyc(dur);
            applyStimulus(7'($urandom), logic'($urandom_range(0, 1)), 3'b000);
            cyc(int'($urandom_range(2, 6)));
            checkOutput($sformatf("rnd%0d_digits", s), {20'd0, o_digit3, o_digit2, o_digit1},
                        {20'd0, m_digit[2], m_digit[1], m_digit[0]});
            checkOutput($sformatf("rnd%0d_valid", s), 32'(o_digitValid), 32'(m_valid));
            checkOutput($sformatf("rnd%0d_blank", s), 32'(o_blank), 32'(m_blank));
            checkOutput($sformatf("rnd%0d_errs", s), 32'(err_seen - e0), 32'(m_errors));
            checkOutput($sformatf("rnd%0d_frames", s), 32'(fd_seen - f0), 32'(m_frames));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch's multiplexed seven-segment drive.
- Samples the scanned segment/enable bus, waits for each digit slot to settle, then decodes the segment pattern back to a 4-bit digit value.
- Holds one register per digit and flags complete frames.
- Used as an on-board readback/monitor for the display bus and as a self-check in the stopwatch bench.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before capture.
- TIMEOUT_CYCLES, 50000: clk cycles with no digit enabled before all valid flags clear.
- SEG_ACTIVE_LOW, 1: segment bus polarity (1 = lit when 0).
- EN_ACTIVE_LOW, 1: enable bus polarity (1 = selected when 0).

Ports:
- i_clk, input, 1: system clock (100 MHz).
- i_rst, input, 1: reset; asynchronous, active-high.
- i_sevenSegment, input, 8: scanned segment bus; bit7..bit1 = a..g, bit0 = dp.
- i_sevenSegmentEnable, input, 3: digit enables; [0] = digit1, [1] = digit2, [2] = digit3.
- o_digit1 / o_digit2 / o_digit3, output, 4 each: last decoded value per digit.
- o_digitValid, output, 3: per-digit "decoded since timeout/reset".
- o_blank, output, 3: per-digit "last capture was all segments off".
- o_frameDone, output, 1: one-cycle pulse when all three digits have been captured since the previous pulse.
- o_error, output, 1: one-cycle pulse on a pattern that does not decode.

Behaviour:
- Reset (async, i_rst=1): all outputs 0, synchronizers cleared, FSM to IDLE, frame mask 0, timeout counter 0.
- Input path:
  - Two-flop synchronizer on all 11 input bits.
  - Polarity normalized per parameters, so internally 1 = lit / selected.
- FSM:
  - IDLE: wait for exactly one enable bit set → SETTLE, latch enable code, load stable counter.
  - SETTLE:
    - Synchronized sample (segments + enable) unchanged → increment counter.
    - Any change → reload counter, stay in SETTLE if still one-hot, else → IDLE.
    - Counter reaches STABLE_CYCLES → CAPTURE.
  - CAPTURE (one cycle): decode and write the selected digit, then → HOLD.
  - HOLD: stay until the enable code changes, so one capture per slot; then → IDLE.
- Enable patterns:
  - Zero enables: inter-digit blanking.
  - Multiple enables set: ignored (ghosting); FSM stays in or returns to IDLE.
  - Neither counts as an error.
- Decode (abcdefg, normalized):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000: digit register unchanged, blank bit set, valid bit set.
  - Any other pattern: register unchanged, o_error pulse in the CAPTURE cycle, valid bit unchanged.
  - dp ignored.
- Latency: synchronizer 2 + STABLE_CYCLES + 1 cycle from a stable slot to the register update.
- Frame mask:
  - Set by each successful capture (including blank).
  - When the mask reaches 3'b111: o_frameDone pulses the following cycle and the mask clears.
  - A capture in that same cycle seeds the new mask.
- Timeout:
  - Counter increments whenever no enable bit is set; resets on any one-hot enable.
  - At TIMEOUT_CYCLES: o_digitValid, o_blank and the frame mask clear. Digit values are held.
  - Counter saturates.
- Mid-operation reset: immediate return to reset state; no partial capture is committed.

Optional Feature:
- Macro: SEVEN_SEGMENT_HEX_DECODE_EN.
- Defined: additionally decodes A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111 to 0xA–0xF.
- Undefined: these patterns raise o_error as above.

Decomposition:
- Package seven_segment_scan_pkg:
  - FSM state encoding (IDLE, SETTLE, CAPTURE, HOLD).
  - The 7-bit segment pattern constants for 0–9 and A–F.
  - Digit-index constants.
- Sub-module segment_pattern_decoder: combinational 7-bit → {valid, blank, 4-bit value}, honoring the macro; instantiated once.

Test Plan:
- Active-low bus; enable=3'b110, seg=8'b0000_0011 (digit 0) held 20000 cycles → o_digit1=0 and o_digitValid[0]=1 at 2+16+1 cycles after the stable sample.
- Scan "1","2","3" on enables 0,1,2, 10000 cycles each with 1000-cycle all-off gaps → o_digit1/2/3 = 1/2/3; o_frameDone pulses once, 1 cycle after the third capture.
- Enable 3'b100 (two digits selected) for 5000 cycles → no capture, no o_error; all digits unchanged.
- Pattern 1110111 (A) on digit2 → macro undefined: one o_error pulse, o_digit2 unchanged. Macro defined: o_digit2=4'hA, no error.
- All enables off for 50000 cycles after a full frame → o_digitValid=3'b000 at the 50000th cycle; digit values retained.
- Assert i_rst during SETTLE at 8 of 16 stable cycles → outputs 0 asynchronously; after release, the next capture requires the full 16-cycle settle.
